branch_unit: RTL and testbench
==============================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning PC/target width in bits.
REQ-002 SHALL have parameter XLEN, default 32, meaning operand/immediate width in bits.
REQ-003 SHALL have parameter PC_STEP, default 1, meaning sequential PC increment (word-addressed).
REQ-004 SHALL have parameter ALIGN_BITS, default 0, meaning the number of target LSBs that must be zero (0 disables the check).
REQ-005 SHALL have parameter CNT_W, default 16, meaning the statistics counter width.
REQ-006 Ports: clk  in  1  sole clock, rising edge; reset is synchronous and active-high.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 flush  in  1  discard the held result and any input accepted this cycle.
REQ-009 in_valid  in  1  request valid; in_ready  out  1  request accepted when in_valid && in_ready.
REQ-010 pc  in  ADDR_W  PC of the branch; imm_ext  in  XLEN  sign-extended offset.
REQ-011 rs1_val, rs2_val  in  XLEN  each  compare operands / base register.
REQ-012 mode  in  2  00 PC+imm, 01 reg, 10 reg+imm, 11 reg+imm with bit0 cleared.
REQ-013 cond  in  3  000 EQ, 001 NE, 010 LT, 011 GE, 100 LTU, 101 GEU, 110 ALWAYS, 111 NEVER.
REQ-014 redir_valid  out  1; redir_ready  in  1  output handshake.
REQ-015 redir_target  out  ADDR_W  next PC; redir_taken  out  1; link_addr  out  ADDR_W  pc+PC_STEP.
REQ-016 misalign  out  1  a taken target violates ALIGN_BITS.
REQ-017 branch_cnt, taken_cnt  out  CNT_W each  resolved/taken statistics.

Function
REQ-018 The block SHALL have states IDLE (no result held) and HOLD (result held, redir_valid=1).
REQ-019 in_ready SHALL be 1 in IDLE, and in HOLD equal to redir_ready (single-entry pipeline, full throughput).
REQ-020 An accepted request SHALL produce its result registered on the next edge: latency 1 cycle.
REQ-021 Transitions: IDLE->HOLD on accept; HOLD->IDLE on redir_ready without a new accept; HOLD->HOLD on a new accept or !redir_ready.
REQ-022 Held outputs SHALL stay stable while redir_valid && !redir_ready.
REQ-023 Raw target SHALL be pc+imm_ext (00), rs1_val (01), rs1_val+imm_ext (10), or (rs1_val+imm_ext) with bit0=0 (11), computed at XLEN and truncated to [ADDR_W-1:0] (modulo 2^ADDR_W wrap).
REQ-024 pc SHALL be zero-extended to XLEN before the add.
REQ-025 LT/GE SHALL compare signed; LTU/GEU SHALL compare unsigned; EQ/NE compare all XLEN bits.
REQ-026 redir_target SHALL be the raw target when taken, else (pc+PC_STEP) mod 2^ADDR_W.
REQ-027 link_addr SHALL be (pc+PC_STEP) mod 2^ADDR_W regardless of taken.
REQ-028 misalign SHALL be 1 iff taken, ALIGN_BITS>0, and target[ALIGN_BITS-1:0]!=0; the target is not modified.
REQ-029 On each output handshake, branch_cnt SHALL increment; taken_cnt SHALL increment if redir_taken && !misalign.
REQ-030 Both counters SHALL saturate at all-ones.
REQ-031 flush SHALL force the state to IDLE and redir_valid=0 on the next edge, drop any same-cycle accept, and leave the counters unchanged.
REQ-032 flush together with a HOLD handshake SHALL still count that handshake.

Reset
REQ-033 On rst: state=IDLE, redir_valid=0, redir_taken=0, misalign=0, redir_target=0, link_addr=0, branch_cnt=0, taken_cnt=0.
REQ-034 rst SHALL take priority over flush and handshakes; in_ready SHALL be 0 while rst=1.
REQ-035 Reset mid-HOLD SHALL discard the held result without counting it.

Structure
REQ-036 Shared package branch_pkg SHALL hold the mode and cond encodings, the state enum, and the MODE_W=2 and COND_W=3 constants.
REQ-037 Condition evaluation SHALL be a sub-module branch_cond (XLEN operands, cond in, taken out, purely combinational).

Verification
REQ-038 pc=8'h10, mode=00, imm=-4, cond=ALWAYS -> one cycle later redir_valid=1, target=8'h0C, link=8'h11, taken=1.
REQ-039 pc=8'hFE, mode=00, imm=5, ALWAYS -> target=8'h03 (wrap); cond=NEVER -> target=8'hFF, taken=0.
REQ-040 rs1=32'hFFFFFFFF, rs2=1: LT -> taken; LTU -> not taken; mode=01 target=8'hFF.
REQ-041 redir_ready=0 for 3 cycles with a new request pending -> outputs stable, in_ready=0, request accepted in the cycle redir_ready rises.
REQ-042 ALIGN_BITS=2, mode=10, rs1=0x21, imm=0, ALWAYS -> misalign=1, target=8'h21, taken_cnt unchanged, branch_cnt+1.
REQ-043 flush in HOLD, and rst in HOLD -> redir_valid=0 next cycle; counters unchanged (flush) / zero (rst); CNT_W=2 with 5 handshakes -> branch_cnt=3.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolution unit.
package branch_pkg;

    localparam int MODE_W = 2;
    localparam int COND_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_PC_IMM      = 2'b00,
        MODE_REG         = 2'b01,
        MODE_REG_IMM     = 2'b10,
        MODE_REG_IMM_CLR = 2'b11
    } mode_e;

    typedef enum logic [COND_W-1:0] {
        COND_EQ     = 3'b000,
        COND_NE     = 3'b001,
        COND_LT     = 3'b010,
        COND_GE     = 3'b011,
        COND_LTU    = 3'b100,
        COND_GEU    = 3'b101,
        COND_ALWAYS = 3'b110,
        COND_NEVER  = 3'b111
    } cond_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluation.
module branch_cond
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [COND_W-1:0] cond,
    output logic              taken
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1_val == rs2_val);
    assign lt_s = ($signed(rs1_val) < $signed(rs2_val));
    assign lt_u = (rs1_val < rs2_val);

    always_comb begin
        taken = 1'b0;
        unique case (cond_e'(cond))
            COND_EQ:     taken = eq;
            COND_NE:     taken = !eq;
            COND_LT:     taken = lt_s;
            COND_GE:     taken = !lt_s;
            COND_LTU:    taken = lt_u;
            COND_GEU:    taken = !lt_u;
            COND_ALWAYS: taken = 1'b1;
            COND_NEVER:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution: single-entry result register with valid/ready
// handshakes, target alignment check and saturating statistics.
module branch_unit
    import branch_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int XLEN       = 32,
    parameter int PC_STEP    = 1,
    parameter int ALIGN_BITS = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc,
    input  logic [XLEN-1:0]   imm_ext,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [MODE_W-1:0] mode,
    input  logic [COND_W-1:0] cond,
    output logic              redir_valid,
    input  logic              redir_ready,
    output logic [ADDR_W-1:0] redir_target,
    output logic              redir_taken,
    output logic [ADDR_W-1:0] link_addr,
    output logic              misalign,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
    // Zero mask when ALIGN_BITS is 0, which disables the check
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << ALIGN_BITS) - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [ADDR_W-1:0] link_q, link_d;
    logic              taken_q, taken_d;
    logic              misalign_q, misalign_d;
    logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

    logic              cond_taken;
    logic [XLEN-1:0]   base;
    logic [XLEN-1:0]   sum;
    logic [XLEN-1:0]   raw;
    logic [ADDR_W-1:0] raw_target;
    logic [ADDR_W-1:0] seq_pc;
    logic              accept;
    logic              hs_out;

    branch_cond #(
        .XLEN(XLEN)
    ) u_cond (
        .rs1_val(rs1_val),
        .rs2_val(rs2_val),
        .cond   (cond),
        .taken  (cond_taken)
    );

    assign redir_valid  = (state_q == ST_HOLD);
    assign in_ready     = !rst && (!redir_valid || redir_ready);
    assign accept       = in_valid && in_ready && !flush;
    assign hs_out       = redir_valid && redir_ready;
    assign redir_target = target_q;
    assign link_addr    = link_q;
    assign redir_taken  = taken_q;
    assign misalign     = misalign_q;
    assign branch_cnt   = branch_cnt_q;
    assign taken_cnt    = taken_cnt_q;

    always_comb begin
        base = (mode_e'(mode) == MODE_PC_IMM) ? XLEN'(pc) : rs1_val;
        sum  = base + imm_ext;
        raw  = (mode_e'(mode) == MODE_REG) ? rs1_val : sum;
        if (mode_e'(mode) == MODE_REG_IMM_CLR) begin
            raw[0] = 1'b0;
        end
        raw_target = raw[ADDR_W-1:0];
        seq_pc     = pc + STEP;
    end

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        link_d       = link_q;
        taken_d      = taken_q;
        misalign_d   = misalign_q;
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;

        if (hs_out) begin
            if (branch_cnt_q != '1) begin
                branch_cnt_d = branch_cnt_q + 1'b1;
            end
            if (taken_q && !misalign_q && taken_cnt_q != '1) begin
                taken_cnt_d = taken_cnt_q + 1'b1;
            end
        end

        if (flush) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            state_d    = ST_HOLD;
            taken_d    = cond_taken;
            target_d   = cond_taken ? raw_target : seq_pc;
            link_d     = seq_pc;
            misalign_d = cond_taken && |(raw_target & ALIGN_MASK);
        end else if (hs_out) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            target_q     <= '0;
            link_q       <= '0;
            taken_q      <= 1'b0;
            misalign_q   <= 1'b0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            link_q       <= link_d;
            taken_q      <= taken_d;
            misalign_q   <= misalign_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench: one instance with alignment checking, one with
// 2-bit counters to exercise saturation, both on shared stimulus.
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [7:0]  pc;
    logic [31:0] imm_ext;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [1:0]  mode;
    logic [2:0]  cond;
    logic        redir_ready;

    logic        a_in_ready, a_valid, a_taken, a_mis;
    logic [7:0]  a_target, a_link;
    logic [15:0] a_br, a_tk;
    logic        s_in_ready, s_valid, s_taken, s_mis;
    logic [7:0]  s_target, s_link;
    logic [1:0]  s_br, s_tk;

    int checks = 0;
    int errors = 0;
    int m_a_br, m_a_tk, m_s_br, m_s_tk;

    always #5 clk = ~clk;

    branch_unit #(
        .ADDR_W(8), .XLEN(32), .PC_STEP(1), .ALIGN_BITS(2), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .pc(pc), .imm_ext(imm_ext), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .mode(mode), .cond(cond),
        .redir_valid(a_valid), .redir_ready(redir_ready),
        .redir_target(a_target), .redir_taken(a_taken),
        .link_addr(a_link), .misalign(a_mis),
        .branch_cnt(a_br), .taken_cnt(a_tk)
    );

    branch_unit #(
        .ADDR_W(8), .XLEN(32), .PC_STEP(1), .ALIGN_BITS(0), .CNT_W(2)
    ) u_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .pc(pc), .imm_ext(imm_ext), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .mode(mode), .cond(cond),
        .redir_valid(s_valid), .redir_ready(redir_ready),
        .redir_target(s_target), .redir_taken(s_taken),
        .link_addr(s_link), .misalign(s_mis),
        .branch_cnt(s_br), .taken_cnt(s_tk)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] p, input logic [31:0] i,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [1:0] m, input logic [2:0] c);
        in_valid = 1'b1;
        pc       = p;
        imm_ext  = i;
        rs1_val  = r1;
        rs2_val  = r2;
        mode     = m;
        cond     = c;
    endtask

    task automatic count_hs(input logic tk, input logic ma, input logic ms);
        m_a_br++;
        if (tk && !ma) m_a_tk++;
        if (m_s_br < 3) m_s_br++;
        if (tk && !ms && m_s_tk < 3) m_s_tk++;
    endtask

    task automatic check_cnt(input string tag);
        check({tag, ".a_br"}, 64'(a_br), 64'(m_a_br));
        check({tag, ".a_tk"}, 64'(a_tk), 64'(m_a_tk));
        check({tag, ".s_br"}, 64'(s_br), 64'(m_s_br));
        check({tag, ".s_tk"}, 64'(s_tk), 64'(m_s_tk));
    endtask

    task automatic check_out(input string tag, input logic [7:0] tgt,
                             input logic tk, input logic [7:0] lnk,
                             input logic ma, input logic ms);
        check({tag, ".a_vld"}, 64'(a_valid), 64'd1);
        check({tag, ".a_tgt"}, 64'(a_target), 64'(tgt));
        check({tag, ".a_tkn"}, 64'(a_taken), 64'(tk));
        check({tag, ".a_lnk"}, 64'(a_link), 64'(lnk));
        check({tag, ".a_mis"}, 64'(a_mis), 64'(ma));
        check({tag, ".s_vld"}, 64'(s_valid), 64'd1);
        check({tag, ".s_tgt"}, 64'(s_target), 64'(tgt));
        check({tag, ".s_mis"}, 64'(s_mis), 64'(ms));
    endtask

    task automatic run(input string tag, input logic [7:0] p,
                       input logic [31:0] i, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [1:0] m,
                       input logic [2:0] c, input logic [7:0] tgt,
                       input logic tk, input logic ma, input logic ms);
        logic [7:0] lnk;
        lnk = p + 8'd1;
        drive(p, i, r1, r2, m, c);
        step();
        in_valid = 1'b0;
        check_out(tag, tgt, tk, lnk, ma, ms);
        step();
        count_hs(tk, ma, ms);
        check({tag, ".idle"}, 64'(a_valid), 64'd0);
        check_cnt(tag);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; redir_ready = 1'b1;
        pc = '0; imm_ext = '0; rs1_val = '0; rs2_val = '0;
        mode = '0; cond = '0;
        m_a_br = 0; m_a_tk = 0; m_s_br = 0; m_s_tk = 0;
        step();
        step();
        check("rst_in_ready", 64'(a_in_ready), 64'd0);
        rst = 1'b0;
        step();
        check("rst_valid", 64'(a_valid), 64'd0);
        check("rst_target", 64'(a_target), 64'd0);
        check("rst_link", 64'(a_link), 64'd0);
        check("rst_taken", 64'(a_taken), 64'd0);
        check("rst_mis", 64'(a_mis), 64'd0);
        check("rst_ready", 64'(a_in_ready), 64'd1);
        check_cnt("rst");

        run("pcimm_neg", 8'h10, 32'hFFFF_FFFC, 0, 0, 2'b00, 3'b110,
            8'h0C, 1, 0, 0);
        run("wrap", 8'hFE, 32'd5, 0, 0, 2'b00, 3'b110, 8'h03, 1, 1, 0);
        run("never", 8'hFE, 32'd5, 0, 0, 2'b00, 3'b111, 8'hFF, 0, 0, 0);
        run("lt", 8'h20, 0, 32'hFFFF_FFFF, 32'd1, 2'b01, 3'b010,
            8'hFF, 1, 1, 0);
        run("ltu", 8'h20, 0, 32'hFFFF_FFFF, 32'd1, 2'b01, 3'b100,
            8'h21, 0, 0, 0);
        run("ge", 8'h20, 0, 32'hFFFF_FFFF, 32'd1, 2'b01, 3'b011,
            8'h21, 0, 0, 0);
        run("geu", 8'h20, 0, 32'hFFFF_FFFF, 32'd1, 2'b01, 3'b101,
            8'hFF, 1, 1, 0);
        run("eq_hi", 8'h40, 0, 32'h100, 32'h0, 2'b01, 3'b000,
            8'h41, 0, 0, 0);
        run("ne_hi", 8'h40, 0, 32'h100, 32'h0, 2'b01, 3'b001,
            8'h00, 1, 0, 0);
        run("clr_bit0", 8'h40, 32'd4, 32'h31, 32'h0, 2'b11, 3'b101,
            8'h34, 1, 0, 0);
        run("misalign", 8'h50, 32'd0, 32'h21, 32'h0, 2'b10, 3'b110,
            8'h21, 1, 1, 0);

        // Backpressure: B waits while A is held
        drive(8'h60, 32'd2, 0, 0, 2'b00, 3'b110);
        step();
        redir_ready = 1'b0;
        drive(8'h70, 32'd8, 0, 0, 2'b00, 3'b110);
        #1;
        check("bp_ready0", 64'(a_in_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_out("bp_hold", 8'h62, 1, 8'h61, 1, 0);
            check("bp_ready", 64'(a_in_ready), 64'd0);
            check_cnt("bp_hold");
        end
        redir_ready = 1'b1;
        #1;
        check("bp_ready1", 64'(a_in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        count_hs(1, 1, 0);
        check_out("bp_b", 8'h78, 1, 8'h71, 0, 0);
        check_cnt("bp_b");
        step();
        count_hs(1, 0, 0);
        check("bp_idle", 64'(a_valid), 64'd0);
        check_cnt("bp_idle");

        // Flush in HOLD without handshake
        drive(8'h80, 32'd4, 0, 0, 2'b00, 3'b110);
        step();
        in_valid = 1'b0; redir_ready = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; redir_ready = 1'b1;
        check("fl_hold_vld", 64'(s_valid), 64'd0);
        check_cnt("fl_hold");

        // Flush drops a same-cycle accept
        drive(8'h84, 32'd4, 0, 0, 2'b00, 3'b110);
        flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("fl_acc_vld", 64'(a_valid), 64'd0);
        check_cnt("fl_acc");

        // Flush alongside an output handshake still counts it
        drive(8'h90, 32'd4, 0, 0, 2'b00, 3'b110);
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        count_hs(1, 0, 0);
        check("fl_hs_vld", 64'(a_valid), 64'd0);
        check_cnt("fl_hs");

        // Reset mid-HOLD
        drive(8'hA0, 32'd4, 0, 0, 2'b00, 3'b110);
        step();
        in_valid = 1'b0; rst = 1'b1;
        #1;
        check("rh_in_ready", 64'(a_in_ready), 64'd0);
        step();
        rst = 1'b0;
        m_a_br = 0; m_a_tk = 0; m_s_br = 0; m_s_tk = 0;
        check("rh_valid", 64'(a_valid), 64'd0);
        check("rh_target", 64'(a_target), 64'd0);
        check("rh_link", 64'(a_link), 64'd0);
        check_cnt("rh");

        for (int k = 0; k < 5; k++) begin
            run("sat", 8'(k), 0, 0, 0, 2'b00, 3'b111,
                8'(k + 1), 0, 0, 0);
        end
        check("sat_s_br", 64'(s_br), 64'd3);
        check("sat_a_br", 64'(a_br), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
